rf_writeback_unit: RTL and testbench

- Write side of the integer register file: merges results from the single-cycle ALU path and the multi-cycle load/mul (LSU) path, then drives the file's write port (rf_write, A3, WB_data).
- Keeps a per-register pending scoreboard so decode can stall on in-flight destinations.
- Sits between EX/MEM result producers and the register file.

---
 rtl/rf_writeback_unit_pkg.sv | 15 +
 rtl/rf_writeback_unit_if.sv | 37 +++
 rtl/rf_writeback_unit_wb_fifo.sv | 77 +++++++
 rtl/rf_writeback_unit.sv | 114 +++++++++++
 tb/tb_rf_writeback_unit.sv | 149 ++++++++++++++
 5 files changed

// File: rtl/rf_writeback_unit_pkg.sv
// rtl/rf_writeback_unit_pkg.sv - shared widths and result record for the register file write side
// Purpose: result width, register address width and the {rd, data} record
// carried by both result producers and the LSU result buffer.
package rf_writeback_unit_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int NREGS  = 1 << REG_AW;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_req_t;

endpackage

// File: rtl/rf_writeback_unit_if.sv
// rtl/rf_writeback_unit_if.sv - producer, scoreboard and register file port bundle
// Purpose: groups the ALU result port, the LSU valid/ready result port, the
// decode scoreboard port and the register file write port.
// Modports: master = producers/decode/register file side,
//           slave  = rf_writeback_unit.
interface rf_writeback_unit_if;
    import rf_writeback_unit_pkg::*;

    logic              alu_valid;
    logic [REG_AW-1:0] alu_rd;
    logic [XLEN-1:0]   alu_data;
    logic              lsu_valid;
    logic              lsu_ready;
    logic [REG_AW-1:0] lsu_rd;
    logic [XLEN-1:0]   lsu_data;
    logic              sb_set;
    logic [REG_AW-1:0] sb_rd;
    logic [NREGS-1:0]  pending;
    logic              rf_write;
    logic [REG_AW-1:0] A3;
    logic [XLEN-1:0]   WB_data;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data,
        output sb_set, sb_rd,
        input  lsu_ready, pending, rf_write, A3, WB_data
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        input  sb_set, sb_rd,
        output lsu_ready, pending, rf_write, A3, WB_data
    );

endinterface

// File: rtl/rf_writeback_unit_wb_fifo.sv
// rtl/rf_writeback_unit_wb_fifo.sv - LSU result buffer, oldest-first
// Purpose: small circular buffer of wb_req_t records.
// Ports: clk, rst (sync, active-low), push/push_data, pop, head (oldest entry),
//        full, empty, count (number of held entries).
module wb_fifo
    import rf_writeback_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  wb_req_t                  push_data,
    input  logic                     pop,
    output wb_req_t                  head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_req_t         mem_q [DEPTH];
    wb_req_t         mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            do_push, do_pop;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    // A push into a full buffer or a pop from an empty one is ignored so the
    // pointers can never run past each other.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/rf_writeback_unit.sv
// rtl/rf_writeback_unit.sv - register file write side: ALU/LSU merge, pending scoreboard
// Purpose: picks one result per cycle (ALU, else buffered LSU, else LSU bypass),
// registers it onto the register file write port, and tracks which
// architectural registers still have a write in flight.
// Ports: clk, rst (sync, active-low), bus (rf_writeback_unit_if.slave):
//        ALU result in, LSU valid/ready result in, sb_set/sb_rd from decode,
//        pending scoreboard out, rf_write/A3/WB_data to the register file.
module rf_writeback_unit
    import rf_writeback_unit_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    rf_writeback_unit_if.slave   bus
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    wb_req_t           alu_req, lsu_req, fifo_head, sel_req;
    logic              fifo_full, fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic              lsu_ready, lsu_xfer;
    logic              sel_valid, sel_pop, sel_byp, fifo_push;

    logic              rf_write_q, rf_write_d;
    logic [REG_AW-1:0] a3_q, a3_d;
    logic [XLEN-1:0]   wb_data_q, wb_data_d;
    logic [NREGS-1:0]  pending_q, pending_d;

    assign alu_req = '{rd: bus.alu_rd, data: bus.alu_data};
    assign lsu_req = '{rd: bus.lsu_rd, data: bus.lsu_data};

    // Ready depends only on registered occupancy, never on lsu_valid, so the
    // producer sees no combinational loop through this unit.
    assign lsu_ready = rst && (fifo_count < CW'(FIFO_DEPTH));
    assign lsu_xfer  = bus.lsu_valid && lsu_ready;

    // ALU first, then the oldest buffered LSU result, then a fresh LSU
    // result straight through; an LSU transfer that loses is buffered.
    always_comb begin
        sel_valid = 1'b0;
        sel_pop   = 1'b0;
        sel_byp   = 1'b0;
        sel_req   = alu_req;
        if (bus.alu_valid) begin
            sel_valid = 1'b1;
        end else if (!fifo_empty) begin
            sel_valid = 1'b1;
            sel_pop   = 1'b1;
            sel_req   = fifo_head;
        end else if (lsu_xfer) begin
            sel_valid = 1'b1;
            sel_byp   = 1'b1;
            sel_req   = lsu_req;
        end
        fifo_push = lsu_xfer && !sel_byp && !fifo_full;
    end

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_wb_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (lsu_req),
        .pop       (sel_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // x0 results still occupy their slot but never reach the file.
    always_comb begin
        rf_write_d = sel_valid && (sel_req.rd != '0);
        a3_d       = sel_valid ? sel_req.rd   : a3_q;
        wb_data_d  = sel_valid ? sel_req.data : wb_data_q;
    end

    // Clear before set so an issue to a register in the same cycle its older
    // write retires leaves the new write pending.
    always_comb begin
        pending_d = pending_q;
        if (sel_valid && (sel_req.rd != '0)) begin
            pending_d[sel_req.rd] = 1'b0;
        end
        if (bus.sb_set && (bus.sb_rd != '0)) begin
            pending_d[bus.sb_rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rf_write_q <= 1'b0;
            a3_q       <= '0;
            wb_data_q  <= '0;
            pending_q  <= '0;
        end else begin
            rf_write_q <= rf_write_d;
            a3_q       <= a3_d;
            wb_data_q  <= wb_data_d;
            pending_q  <= pending_d;
        end
    end

    assign bus.lsu_ready = lsu_ready;
    assign bus.rf_write  = rf_write_q;
    assign bus.A3        = a3_q;
    assign bus.WB_data   = wb_data_q;
    assign bus.pending   = pending_q;

endmodule

// File: tb/tb_rf_writeback_unit.sv
// tb/tb_rf_writeback_unit.sv - self-checking bench for rf_writeback_unit
module tb_rf_writeback_unit;
    import rf_writeback_unit_pkg::*;

    typedef struct {
        logic        rst;
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adat;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ldat;
        logic        ss;
        logic [4:0]  srd;
        logic        rdy;
        logic        we;
        logic [4:0]  wrd;
        logic [31:0] wdat;
        logic [31:0] pend;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;
    vec_t tbl[$];
    vec_t exp_q[$];

    always #5 clk = ~clk;

    rf_writeback_unit_if ifc ();

    rf_writeback_unit #(
        .FIFO_DEPTH (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    function automatic vec_t mk(input logic r, input logic av, input logic [4:0] ard,
                                input logic [31:0] adat, input logic lv, input logic [4:0] lrd,
                                input logic [31:0] ldat, input logic ss, input logic [4:0] srd,
                                input logic rdy, input logic we, input logic [4:0] wrd,
                                input logic [31:0] wdat, input logic [31:0] pend);
        vec_t v;
        v.rst = r;   v.av = av;   v.ard = ard; v.adat = adat;
        v.lv = lv;   v.lrd = lrd; v.ldat = ldat;
        v.ss = ss;   v.srd = srd; v.rdy = rdy;
        v.we = we;   v.wrd = wrd; v.wdat = wdat; v.pend = pend;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus, check ready, queue the expected write and
    // compare it once the clock edge has registered the selection.
    task automatic step(input vec_t v, input int idx);
        vec_t e;
        @(negedge clk);
        rst           = v.rst;
        ifc.alu_valid = v.av;
        ifc.alu_rd    = v.ard;
        ifc.alu_data  = v.adat;
        ifc.lsu_valid = v.lv;
        ifc.lsu_rd    = v.lrd;
        ifc.lsu_data  = v.ldat;
        ifc.sb_set    = v.ss;
        ifc.sb_rd     = v.srd;
        #1;
        chk($sformatf("lsu_ready[%0d]", idx), 32'(ifc.lsu_ready), 32'(v.rdy));
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk($sformatf("scoreboard_empty[%0d]", idx), 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk($sformatf("rf_write[%0d]", idx), 32'(ifc.rf_write), 32'(e.we));
            if (e.we) begin
                chk($sformatf("A3[%0d]", idx), 32'(ifc.A3), 32'(e.wrd));
                chk($sformatf("WB_data[%0d]", idx), ifc.WB_data, e.wdat);
            end
            chk($sformatf("pending[%0d]", idx), ifc.pending, e.pend);
        end
    endtask

    initial begin
        rst = 1'b0;
        ifc.alu_valid = 1'b0; ifc.alu_rd = '0; ifc.alu_data = '0;
        ifc.lsu_valid = 1'b0; ifc.lsu_rd = '0; ifc.lsu_data = '0;
        ifc.sb_set = 1'b0;    ifc.sb_rd = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rf_write", 32'(ifc.rf_write), 32'd0);
        chk("reset_A3", 32'(ifc.A3), 32'd0);
        chk("reset_WB_data", ifc.WB_data, 32'd0);
        chk("reset_pending", ifc.pending, 32'd0);
        chk("reset_lsu_ready", 32'(ifc.lsu_ready), 32'd0);

        //              rst   av    ard    adat           lv    lrd     ldat           ss    srd    rdy   we    wrd     wdat           pend
        tbl.push_back(mk(1'b1, 1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         1'b1, 5'd5, 1'b1, 1'b0, 5'd0,  32'h0,         32'h0000_0020));
        tbl.push_back(mk(1'b1, 1'b1, 5'd5,  32'h1234_5678, 1'b0, 5'd0,  32'h0,         1'b0, 5'd0, 1'b1, 1'b1, 5'd5,  32'h1234_5678, 32'h0));
        tbl.push_back(mk(1'b1, 1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         1'b1, 5'd7, 1'b1, 1'b0, 5'd0,  32'h0,         32'h0000_0080));
        tbl.push_back(mk(1'b1, 1'b0, 5'd0,  32'h0,         1'b1, 5'd7,  32'hDEAD_BEEF, 1'b0, 5'd0, 1'b1, 1'b1, 5'd7,  32'hDEAD_BEEF, 32'h0));
        tbl.push_back(mk(1'b1, 1'b1, 5'd3,  32'h11,        1'b1, 5'd4,  32'h22,        1'b0, 5'd0, 1'b1, 1'b1, 5'd3,  32'h11,        32'h0));
        tbl.push_back(mk(1'b1, 1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         1'b0, 5'd0, 1'b1, 1'b1, 5'd4,  32'h22,        32'h0));
        tbl.push_back(mk(1'b1, 1'b1, 5'd1,  32'hA1,        1'b1, 5'd8,  32'h88,        1'b0, 5'd0, 1'b1, 1'b1, 5'd1,  32'hA1,        32'h0));
        tbl.push_back(mk(1'b1, 1'b1, 5'd2,  32'hA2,        1'b1, 5'd9,  32'h99,        1'b0, 5'd0, 1'b1, 1'b1, 5'd2,  32'hA2,        32'h0));
        tbl.push_back(mk(1'b1, 1'b1, 5'd11, 32'hA3,        1'b1, 5'd10, 32'h1010,      1'b0, 5'd0, 1'b0, 1'b1, 5'd11, 32'hA3,        32'h0));
        tbl.push_back(mk(1'b1, 1'b1, 5'd12, 32'hA4,        1'b1, 5'd10, 32'h1010,      1'b0, 5'd0, 1'b0, 1'b1, 5'd12, 32'hA4,        32'h0));
        tbl.push_back(mk(1'b1, 1'b0, 5'd0,  32'h0,         1'b1, 5'd10, 32'h1010,      1'b0, 5'd0, 1'b0, 1'b1, 5'd8,  32'h88,        32'h0));
        tbl.push_back(mk(1'b1, 1'b0, 5'd0,  32'h0,         1'b1, 5'd10, 32'h1010,      1'b0, 5'd0, 1'b1, 1'b1, 5'd9,  32'h99,        32'h0));
        tbl.push_back(mk(1'b1, 1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         1'b0, 5'd0, 1'b1, 1'b1, 5'd10, 32'h1010,      32'h0));
        tbl.push_back(mk(1'b1, 1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         1'b1, 5'd6, 1'b1, 1'b0, 5'd0,  32'h0,         32'h0000_0040));
        tbl.push_back(mk(1'b1, 1'b1, 5'd6,  32'h66,        1'b0, 5'd0,  32'h0,         1'b1, 5'd6, 1'b1, 1'b1, 5'd6,  32'h66,        32'h0000_0040));
        tbl.push_back(mk(1'b1, 1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  32'h0,         1'b1, 5'd0, 1'b1, 1'b0, 5'd0,  32'h0,         32'h0000_0040));
        tbl.push_back(mk(1'b1, 1'b1, 5'd0,  32'h77,        1'b0, 5'd0,  32'h0,         1'b0, 5'd0, 1'b1, 1'b0, 5'd0,  32'h0,         32'h0000_0040));
        tbl.push_back(mk(1'b1, 1'b0, 5'd0,  32'h0,         1'b1, 5'd0,  32'h5,         1'b0, 5'd0, 1'b1, 1'b0, 5'd0,  32'h0,         32'h0000_0040));
        tbl.push_back(mk(1'b1, 1'b1, 5'd6,  32'h66,        1'b0, 5'd0,  32'h0,         1'b1, 5'd9, 1'b1, 1'b1, 5'd6,  32'h66,        32'h0000_0200));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i], i);
        end

        // Reset with two buffered LSU results and pending bits set: nothing
        // buffered may surface after release, and occupancy restarts at zero.
        step(mk(1'b1, 1'b1, 5'd1, 32'hD1, 1'b1, 5'd13, 32'hD13, 1'b1, 5'd20, 1'b1, 1'b1, 5'd1, 32'hD1, 32'h0010_0200), 100);
        step(mk(1'b1, 1'b1, 5'd2, 32'hD2, 1'b1, 5'd14, 32'hD14, 1'b0, 5'd0,  1'b1, 1'b1, 5'd2, 32'hD2, 32'h0010_0200), 101);
        step(mk(1'b0, 1'b1, 5'd3, 32'hD3, 1'b1, 5'd15, 32'hD15, 1'b1, 5'd21, 1'b0, 1'b0, 5'd0, 32'h0,  32'h0), 102);
        step(mk(1'b1, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0,  32'h0,   1'b0, 5'd0,  1'b1, 1'b0, 5'd0, 32'h0,  32'h0), 103);
        step(mk(1'b1, 1'b1, 5'd1, 32'hE1, 1'b1, 5'd15, 32'hE15, 1'b0, 5'd0,  1'b1, 1'b1, 5'd1, 32'hE1, 32'h0), 104);
        step(mk(1'b1, 1'b1, 5'd2, 32'hE2, 1'b1, 5'd16, 32'hE16, 1'b0, 5'd0,  1'b1, 1'b1, 5'd2, 32'hE2, 32'h0), 105);
        step(mk(1'b1, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0,  32'h0,   1'b0, 5'd0,  1'b0, 1'b1, 5'd15, 32'hE15, 32'h0), 106);
        step(mk(1'b1, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0,  32'h0,   1'b0, 5'd0,  1'b1, 1'b1, 5'd16, 32'hE16, 32'h0), 107);
        step(mk(1'b1, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0,  32'h0,   1'b0, 5'd0,  1'b1, 1'b0, 5'd0, 32'h0,  32'h0), 108);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
